spmv_job_launcher: RTL and testbench
====================================

Name: spmv_job_launcher

Overview:
- Per-kernel job sequencer downstream of the SpMV configuration register file.
- Consumes one kernel's 96-bit config slice (ctrl, row count, nnz count) and detects a software start.
- Issues a job descriptor to one SpMV kernel over a valid/ready handshake, tracks completion, timeout and abort, and reports status, cycle count and an interrupt pulse.
- The top level instantiates one launcher per kernel (CONF_NUM_KERNEL instances).

Parameters:
- TIMEOUT_CYCLES, 32'd0: RUN-state cycle limit; 0 disables the timeout.
- JOB_ID_W, 16: width of the accepted-job counter reported in status[31:16].

Ports:
- aclk  in  1  single clock.
- areset  in  1  synchronous reset, active-high.
- cfg_ctrl  in  32  ctrl word: [0] start (level), [1] abort (level), [2] irq_en; other bits ignored.
- cfg_row_num  in  32  row count for the job.
- cfg_nnz_num  in  32  nonzero count for the job.
- job_valid  out  1  descriptor valid.
- job_ready  in  1  kernel accepts descriptor.
- job_row_num  out  32  latched row count.
- job_nnz_num  out  32  latched nnz count.
- kernel_done  in  1  one-cycle completion pulse from the kernel.
- kernel_abort  out  1  one-cycle abort pulse to the kernel.
- status  out  32  [0] busy, [1] done, [2] err_zero, [3] err_timeout, [4] err_abort, [5] overrun, [15:6] zero, [31:16] job_id.
- cycle_count  out  32  RUN-state cycles of the current or last job.
- irq  out  1  one-cycle completion interrupt.

Behaviour:
- Reset (areset=1 at aclk edge): state=IDLE. All outputs 0: job_valid, job_row_num, job_nnz_num, kernel_abort, status, cycle_count, irq. Internal start_q=0.
- Start detection: start_edge = cfg_ctrl[0] & ~start_q, with start_q registered every cycle. A held level produces exactly one edge.
- IDLE, on start_edge:
  - Clear status[5:1] and cycle_count.
  - Latch cfg_row_num and cfg_nnz_num into job_row_num and job_nnz_num.
  - If either value is 0: go to DONE with err_zero=1. No descriptor is issued and job_id is unchanged.
  - Otherwise go to ISSUE.
- ISSUE:
  - job_valid=1, starting the cycle after the edge. Descriptor fields stay stable while valid.
  - Handshake when job_valid & job_ready: job_id increments (wraps at 2^JOB_ID_W), state goes to RUN.
  - Abort seen during ISSUE is recorded. It takes effect in the cycle after the handshake; valid is never withdrawn.
- RUN:
  - cycle_count increments every cycle, saturating at 32'hFFFFFFFF.
  - kernel_done moves to DONE.
  - Abort (cfg_ctrl[1]=1, or an abort recorded in ISSUE): kernel_abort=1 for one cycle, err_abort=1, go to DONE.
  - Timeout (TIMEOUT_CYCLES≠0 and cycle_count==TIMEOUT_CYCLES-1): kernel_abort pulse, err_timeout=1, go to DONE.
  - Priority when events coincide in the same cycle: kernel_done > abort > timeout.
- DONE (one cycle):
  - done=1 (sticky until the next accepted start).
  - irq=1 for this cycle iff cfg_ctrl[2].
  - Next state IDLE.
- busy = (state≠IDLE). This includes DONE and follows the registered state.
- Start_edge while not in IDLE: overrun=1 (sticky until the next accepted start). The edge is otherwise ignored and start_q still updates.
- Job handshake and kernel_done in the same cycle are impossible by kernel contract. If kernel_done arrives outside RUN it is ignored.
- Reset mid-operation: outputs return to reset values immediately (next edge) and no abort pulse is emitted. The kernel has its own reset.
- Latency: start_edge to job_valid is 1 cycle. kernel_done to irq is 1 cycle.

Decomposition:
- Package spmv_pkg holds:
  - enum launcher_state_t {IDLE, ISSUE, RUN, DONE};
  - ctrl bit index constants CTRL_START=0, CTRL_ABORT=1, CTRL_IRQ_EN=2;
  - status bit index constants;
  - SPMV_CFG_W=96.
- One sub-module: spmv_sat_counter (32-bit clear/enable saturating counter), reused for cycle_count.

Test Plan:
- Normal job: row=100, nnz=500, irq_en=1, start=1. job_ready is low for 3 cycles, then high. kernel_done comes 20 cycles after the handshake. Required: job_valid high for 4 cycles with fields 100/500; status=0x0001_0002 after DONE; cycle_count=20; one irq pulse.
- Zero-size: nnz=0, start. Required: job_valid never asserts; status[2:1]=2'b11; job_id unchanged; irq pulse iff irq_en.
- Timeout: TIMEOUT_CYCLES=50, no kernel_done. Required: kernel_abort pulse at RUN cycle 50; cycle_count=50; err_timeout=1.
- Abort during ISSUE: assert abort while job_ready=0, then job_ready=1 after 5 cycles. Required: job_valid stays high until the handshake; kernel_abort the next cycle; err_abort=1; job_id incremented.
- Overrun/level start: start held high through the whole job, then a 0→1 retoggle during RUN. Required: exactly one job issued; overrun=1; the next clean start clears overrun.
- Reset mid-RUN: areset for 1 cycle. Required: all outputs 0 next cycle, no kernel_abort, state IDLE.

Source files
------------

// File: rtl/spmv_pkg.sv
// Shared types and constants for the SpMV job launcher.
// Contents: launcher FSM states, ctrl/status bit indices, config slice layout.
// No logic; imported by every launcher file.
package spmv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } launcher_state_t;

    // ctrl word bit positions
    localparam int CTRL_START  = 0;
    localparam int CTRL_ABORT  = 1;
    localparam int CTRL_IRQ_EN = 2;

    // status word bit positions; [15:6] zero, [31:16] job id
    localparam int ST_BUSY        = 0;
    localparam int ST_DONE        = 1;
    localparam int ST_ERR_ZERO    = 2;
    localparam int ST_ERR_TIMEOUT = 3;
    localparam int ST_ERR_ABORT   = 4;
    localparam int ST_OVERRUN     = 5;

    // One kernel's slice of the configuration register file
    localparam int SPMV_CFG_W = 96;

    typedef struct packed {
        logic [31:0] nnz_num;
        logic [31:0] row_num;
        logic [31:0] ctrl;
    } spmv_cfg_t;

endpackage

// File: rtl/spmv_sat_counter.sv
// 32-bit counter with synchronous clear and enable, saturating at all-ones.
// Ports: clk, rst (sync, active-high), clr (priority over en), en, count.
// Latency: count reflects clr/en one cycle later; no backpressure.
module spmv_sat_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    output logic [31:0] count
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != 32'hFFFF_FFFF)) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/spmv_job_launcher.sv
// Per-kernel job sequencer: start detect, descriptor issue, completion/abort/timeout tracking.
// Ports: aclk/areset, cfg_* slice in, job_* valid/ready descriptor out, kernel_done in,
//        kernel_abort/status/cycle_count/irq out. Latency: start edge -> job_valid 1 cycle,
//        kernel_done -> irq 1 cycle. Backpressure: job_valid held with stable fields until job_ready.
module spmv_job_launcher
    import spmv_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd0,
    parameter int          JOB_ID_W       = 16
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [31:0] cfg_ctrl,
    input  logic [31:0] cfg_row_num,
    input  logic [31:0] cfg_nnz_num,
    output logic        job_valid,
    input  logic        job_ready,
    output logic [31:0] job_row_num,
    output logic [31:0] job_nnz_num,
    input  logic        kernel_done,
    output logic        kernel_abort,
    output logic [31:0] status,
    output logic [31:0] cycle_count,
    output logic        irq
);

    logic [SPMV_CFG_W-1:0] cfg_flat;
    spmv_cfg_t             cfg;

    assign cfg_flat = {cfg_nnz_num, cfg_row_num, cfg_ctrl};
    assign cfg      = spmv_cfg_t'(cfg_flat);

    // ctrl bits above irq_en carry no meaning for the launcher
    logic unused_ctrl_bits;
    assign unused_ctrl_bits = ^cfg.ctrl[31:3];

    launcher_state_t     state_q, state_d;
    logic                start_q;
    logic [31:0]         row_q, row_d;
    logic [31:0]         nnz_q, nnz_d;
    logic [JOB_ID_W-1:0] job_id_q, job_id_d;
    logic                done_q, done_d;
    logic                err_zero_q, err_zero_d;
    logic                err_to_q, err_to_d;
    logic                err_ab_q, err_ab_d;
    logic                overrun_q, overrun_d;
    logic                abort_pend_q, abort_pend_d;

    logic start_edge;
    logic abort_req;
    logic timeout_hit;
    logic cnt_clr;
    logic cnt_en;
    logic kabort;

    assign start_edge  = cfg.ctrl[CTRL_START] & ~start_q;
    // An abort seen while the descriptor was still pending is replayed on the first RUN cycle
    assign abort_req   = cfg.ctrl[CTRL_ABORT] | abort_pend_q;
    assign timeout_hit = (TIMEOUT_CYCLES != 32'd0) && (cycle_count == (TIMEOUT_CYCLES - 32'd1));

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        nnz_d        = nnz_q;
        job_id_d     = job_id_q;
        done_d       = done_q;
        err_zero_d   = err_zero_q;
        err_to_d     = err_to_q;
        err_ab_d     = err_ab_q;
        overrun_d    = overrun_q;
        abort_pend_d = abort_pend_q;
        cnt_clr      = 1'b0;
        cnt_en       = 1'b0;
        kabort       = 1'b0;

        if (start_edge && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                abort_pend_d = 1'b0;
                if (start_edge) begin
                    done_d     = 1'b0;
                    err_zero_d = 1'b0;
                    err_to_d   = 1'b0;
                    err_ab_d   = 1'b0;
                    overrun_d  = 1'b0;
                    cnt_clr    = 1'b1;
                    row_d      = cfg.row_num;
                    nnz_d      = cfg.nnz_num;
                    if ((cfg.row_num == 32'd0) || (cfg.nnz_num == 32'd0)) begin
                        err_zero_d = 1'b1;
                        done_d     = 1'b1;
                        state_d    = DONE;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (cfg.ctrl[CTRL_ABORT]) begin
                    abort_pend_d = 1'b1;
                end
                if (job_ready) begin
                    job_id_d = job_id_q + 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                cnt_en = 1'b1;
                if (kernel_done) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (abort_req) begin
                    kabort   = 1'b1;
                    err_ab_d = 1'b1;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else if (timeout_hit) begin
                    kabort   = 1'b1;
                    err_to_d = 1'b1;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                abort_pend_d = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= IDLE;
            start_q      <= 1'b0;
            row_q        <= '0;
            nnz_q        <= '0;
            job_id_q     <= '0;
            done_q       <= 1'b0;
            err_zero_q   <= 1'b0;
            err_to_q     <= 1'b0;
            err_ab_q     <= 1'b0;
            overrun_q    <= 1'b0;
            abort_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_q      <= cfg.ctrl[CTRL_START];
            row_q        <= row_d;
            nnz_q        <= nnz_d;
            job_id_q     <= job_id_d;
            done_q       <= done_d;
            err_zero_q   <= err_zero_d;
            err_to_q     <= err_to_d;
            err_ab_q     <= err_ab_d;
            overrun_q    <= overrun_d;
            abort_pend_q <= abort_pend_d;
        end
    end

    spmv_sat_counter u_cycle_cnt (
        .clk   (aclk),
        .rst   (areset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (cycle_count)
    );

    assign job_valid   = (state_q == ISSUE);
    assign job_row_num = row_q;
    assign job_nnz_num = nnz_q;
    // The kernel resets itself; never send it an abort while we are being reset
    assign kernel_abort = kabort & ~areset;
    assign irq          = (state_q == DONE) & cfg.ctrl[CTRL_IRQ_EN];
    assign status       = {16'(job_id_q), 10'd0, overrun_q, err_ab_q, err_to_q,
                           err_zero_q, done_q, (state_q != IDLE)};

endmodule

// File: tb/tb_spmv_job_launcher.sv
module tb_spmv_job_launcher;

    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] cfg_ctrl, cfg_row_num, cfg_nnz_num;
    logic        job_valid, job_ready;
    logic [31:0] job_row_num, job_nnz_num;
    logic        kernel_done, kernel_abort;
    logic [31:0] status, cycle_count;
    logic        irq;

    int checks   = 0;
    int failures = 0;
    int exp_id   = 0;   // accepted-job count expected in status[31:16]

    always #5 aclk = ~aclk;

    spmv_job_launcher #(.TIMEOUT_CYCLES(32'd50), .JOB_ID_W(16)) dut (
        .aclk(aclk), .areset(areset),
        .cfg_ctrl(cfg_ctrl), .cfg_row_num(cfg_row_num), .cfg_nnz_num(cfg_nnz_num),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_row_num(job_row_num), .job_nnz_num(job_nnz_num),
        .kernel_done(kernel_done), .kernel_abort(kernel_abort),
        .status(status), .cycle_count(cycle_count), .irq(irq)
    );

    // Inputs change just after the falling edge; outputs are sampled 1ns later.
    task automatic nxt();
        @(negedge aclk);
    endtask

    function automatic logic [31:0] st(input logic [15:0] flags);
        logic [15:0] id16;
        id16 = 16'(exp_id);
        return {id16, flags};
    endfunction

    task automatic test_reset();
        areset = 1'b1; cfg_ctrl = '0; cfg_row_num = '0; cfg_nnz_num = '0;
        job_ready = 1'b0; kernel_done = 1'b0;
        nxt(); nxt(); #1;
        checks++; if (status !== 32'd0) begin failures++; $display("FAIL reset_status got=%h exp=0", status); end
        checks++; if ({job_valid, kernel_abort, irq} !== 3'b000) begin failures++; $display("FAIL reset_ctl got=%b exp=000", {job_valid, kernel_abort, irq}); end
        checks++; if ({job_row_num, job_nnz_num, cycle_count} !== 96'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", {job_row_num, job_nnz_num, cycle_count}); end
        nxt(); areset = 1'b0;
        exp_id = 0;
    endtask

    // r = cycles job_ready stays low, d = RUN cycles until kernel_done
    task automatic test_normal(input int r, input int d, input bit irq_en,
                               input logic [31:0] row, input logic [31:0] nnz);
        int vcnt, icnt, acnt;
        vcnt = 0; icnt = 0; acnt = 0;
        nxt();
        cfg_row_num = row; cfg_nnz_num = nnz; cfg_ctrl = {29'd0, irq_en, 2'b01};
        job_ready = 1'b0; kernel_done = 1'b0;
        for (int k = 0; k <= r + d + 1; k++) begin
            nxt();
            cfg_ctrl[0] = 1'b0;
            job_ready   = (k >= r);
            kernel_done = (k == r + d);
            #1;
            vcnt += int'(job_valid); icnt += int'(irq); acnt += int'(kernel_abort);
            if (k <= r) begin
                checks++; if (!job_valid || job_row_num !== row || job_nnz_num !== nnz) begin
                    failures++; $display("FAIL normal_desc k=%0d got=%b/%0d/%0d exp=1/%0d/%0d", k, job_valid, job_row_num, job_nnz_num, row, nnz); end
            end else if (k <= r + d) begin
                checks++; if (cycle_count !== 32'(k - r - 1)) begin
                    failures++; $display("FAIL normal_run_count got=%0d exp=%0d", cycle_count, k - r - 1); end
            end else begin
                exp_id = (exp_id + 1) & 16'hFFFF;
                checks++; if (status !== st(16'h0003)) begin failures++; $display("FAIL normal_done_status got=%h exp=%h", status, st(16'h0003)); end
                checks++; if (irq !== irq_en) begin failures++; $display("FAIL normal_irq got=%b exp=%b", irq, irq_en); end
            end
        end
        kernel_done = 1'b0; job_ready = 1'b0;
        checks++; if (vcnt != r + 1) begin failures++; $display("FAIL normal_valid_cycles got=%0d exp=%0d", vcnt, r + 1); end
        checks++; if (icnt != int'(irq_en) || acnt != 0) begin failures++; $display("FAIL normal_pulses got=irq%0d/abort%0d exp=irq%0d/abort0", icnt, acnt, irq_en); end
        nxt(); #1;
        checks++; if (status !== st(16'h0002) || cycle_count !== 32'(d)) begin
            failures++; $display("FAIL normal_final got=%h/%0d exp=%h/%0d", status, cycle_count, st(16'h0002), d); end
    endtask

    task automatic test_zero_size(input bit zero_row, input bit irq_en);
        logic [31:0] row, nnz;
        row = zero_row ? 32'd0 : 32'($urandom_range(1, 5000));
        nnz = zero_row ? 32'($urandom_range(1, 5000)) : 32'd0;
        nxt();
        cfg_row_num = row; cfg_nnz_num = nnz; cfg_ctrl = {29'd0, irq_en, 2'b01};
        nxt(); cfg_ctrl[0] = 1'b0; #1;
        checks++; if (job_valid !== 1'b0 || status !== st(16'h0007)) begin
            failures++; $display("FAIL zero_done got=v%b/%h exp=v0/%h", job_valid, status, st(16'h0007)); end
        checks++; if (irq !== irq_en) begin failures++; $display("FAIL zero_irq got=%b exp=%b", irq, irq_en); end
        checks++; if (job_row_num !== row || job_nnz_num !== nnz) begin
            failures++; $display("FAIL zero_latch got=%0d/%0d exp=%0d/%0d", job_row_num, job_nnz_num, row, nnz); end
        nxt(); #1;
        checks++; if (job_valid !== 1'b0 || status !== st(16'h0006) || cycle_count !== 32'd0) begin
            failures++; $display("FAIL zero_final got=v%b/%h/%0d exp=v0/%h/0", job_valid, status, cycle_count, st(16'h0006)); end
    endtask

    task automatic test_timeout(input int r);
        int acnt;
        acnt = 0;
        nxt();
        cfg_row_num = 32'd7; cfg_nnz_num = 32'd9; cfg_ctrl = 32'd1;
        for (int k = 0; k <= r + 51; k++) begin
            nxt(); cfg_ctrl = '0; job_ready = (k == r); #1;
            acnt += int'(kernel_abort);
            if (k > r && k <= r + 50) begin
                checks++; if (kernel_abort !== (k == r + 50)) begin
                    failures++; $display("FAIL timeout_pulse run_cycle=%0d got=%b exp=%b", k - r, kernel_abort, (k == r + 50)); end
            end
        end
        exp_id = (exp_id + 1) & 16'hFFFF;
        checks++; if (status !== st(16'h000B) || acnt != 1) begin
            failures++; $display("FAIL timeout_done got=%h/pulses%0d exp=%h/pulses1", status, acnt, st(16'h000B)); end
        nxt(); #1;
        checks++; if (cycle_count !== 32'd50 || status !== st(16'h000A)) begin
            failures++; $display("FAIL timeout_final got=%0d/%h exp=50/%h", cycle_count, status, st(16'h000A)); end
    endtask

    // Abort is pulsed only in the first ISSUE cycle, so the late abort relies on it being remembered
    task automatic test_abort_issue(input int r);
        int vcnt;
        vcnt = 0;
        nxt();
        cfg_row_num = 32'd11; cfg_nnz_num = 32'd22; cfg_ctrl = 32'd1;
        for (int k = 0; k <= r + 2; k++) begin
            nxt(); cfg_ctrl = (k == 0) ? 32'd2 : 32'd0; job_ready = (k == r); #1;
            vcnt += int'(job_valid);
            checks++; if (kernel_abort !== (k == r + 1)) begin
                failures++; $display("FAIL abort_issue_pulse k=%0d got=%b exp=%b", k, kernel_abort, (k == r + 1)); end
        end
        exp_id = (exp_id + 1) & 16'hFFFF;
        checks++; if (vcnt != r + 1) begin failures++; $display("FAIL abort_issue_valid got=%0d exp=%0d", vcnt, r + 1); end
        checks++; if (status !== st(16'h0013) || cycle_count !== 32'd1) begin
            failures++; $display("FAIL abort_issue_done got=%h/%0d exp=%h/1", status, cycle_count, st(16'h0013)); end
        job_ready = 1'b0;
        nxt(); #1;
    endtask

    // Live abort on RUN cycle a, competing with nothing
    task automatic test_abort_run(input int r, input int a);
        nxt();
        cfg_row_num = 32'd3; cfg_nnz_num = 32'd4; cfg_ctrl = 32'd1;
        for (int k = 0; k <= r + a + 1; k++) begin
            nxt(); cfg_ctrl = (k == r + a) ? 32'd2 : 32'd0; job_ready = (k >= r); #1;
            if (k > r && k <= r + a) begin
                checks++; if (kernel_abort !== (k == r + a)) begin
                    failures++; $display("FAIL abort_run_pulse k=%0d got=%b exp=%b", k, kernel_abort, (k == r + a)); end
            end
        end
        exp_id = (exp_id + 1) & 16'hFFFF;
        checks++; if (status !== st(16'h0013) || cycle_count !== 32'(a)) begin
            failures++; $display("FAIL abort_run_done got=%h/%0d exp=%h/%0d", status, cycle_count, st(16'h0013), a); end
        job_ready = 1'b0;
        nxt(); #1;
    endtask

    task automatic test_overrun(input int r, input int d, input int m);
        int vcnt;
        vcnt = 0;
        nxt();
        cfg_row_num = 32'd50; cfg_nnz_num = 32'd60; cfg_ctrl = 32'd1;
        for (int k = 0; k <= r + d + 1; k++) begin
            nxt();
            cfg_ctrl    = (k == r + m) ? 32'd0 : 32'd1;
            job_ready   = (k >= r);
            kernel_done = (k == r + d);
            #1;
            vcnt += int'(job_valid);
        end
        kernel_done = 1'b0; job_ready = 1'b0;
        exp_id = (exp_id + 1) & 16'hFFFF;
        checks++; if (vcnt != r + 1 || status !== st(16'h0023)) begin
            failures++; $display("FAIL overrun_done got=v%0d/%h exp=v%0d/%h", vcnt, status, r + 1, st(16'h0023)); end
        // start still held high: no new job may launch
        nxt(); #1; nxt(); #1;
        checks++; if (job_valid !== 1'b0 || status !== st(16'h0022)) begin
            failures++; $display("FAIL overrun_level got=v%b/%h exp=v0/%h", job_valid, status, st(16'h0022)); end
        nxt(); cfg_ctrl = 32'd0;
        nxt(); cfg_ctrl = 32'd1;
        nxt(); job_ready = 1'b1; #1;
        checks++; if (job_valid !== 1'b1 || status !== st(16'h0001)) begin
            failures++; $display("FAIL overrun_clear got=v%b/%h exp=v1/%h", job_valid, status, st(16'h0001)); end
        nxt(); job_ready = 1'b0; kernel_done = 1'b1; cfg_ctrl = 32'd0;
        nxt(); kernel_done = 1'b0;
        nxt(); #1;
        exp_id = (exp_id + 1) & 16'hFFFF;
        checks++; if (status !== st(16'h0002) || cycle_count !== 32'd1) begin
            failures++; $display("FAIL overrun_second got=%h/%0d exp=%h/1", status, cycle_count, st(16'h0002)); end
    endtask

    task automatic test_reset_mid(input int n);
        int acnt;
        acnt = 0;
        nxt();
        cfg_row_num = 32'd5; cfg_nnz_num = 32'd6; cfg_ctrl = 32'd5;
        nxt(); cfg_ctrl = 32'd4; job_ready = 1'b1;
        for (int j = 0; j < n; j++) begin
            nxt(); job_ready = 1'b0; #1;
        end
        nxt(); areset = 1'b1; #1;
        acnt += int'(kernel_abort);
        nxt(); areset = 1'b0; #1;
        acnt += int'(kernel_abort);
        exp_id = 0;
        checks++; if (acnt != 0) begin failures++; $display("FAIL reset_mid_abort got=%0d exp=0", acnt); end
        checks++; if (status !== 32'd0 || cycle_count !== 32'd0 || {job_valid, irq} !== 2'b00) begin
            failures++; $display("FAIL reset_mid_outputs got=%h/%0d/%b exp=0/0/00", status, cycle_count, {job_valid, irq}); end
        checks++; if (job_row_num !== 32'd0 || job_nnz_num !== 32'd0) begin
            failures++; $display("FAIL reset_mid_fields got=%0d/%0d exp=0/0", job_row_num, job_nnz_num); end
        nxt(); #1;
        checks++; if (status !== 32'd0 || job_valid !== 1'b0) begin
            failures++; $display("FAIL reset_mid_idle got=%h/v%b exp=0/v0", status, job_valid); end
        cfg_ctrl = 32'd0;
    endtask

    initial begin
        test_reset();
        test_normal(3, 20, 1'b1, 32'd100, 32'd500);
        for (int i = 0; i < 4; i++) begin
            test_normal($urandom_range(0, 6), $urandom_range(1, 40), 1'($urandom_range(0, 1)),
                        32'($urandom_range(1, 100000)), 32'($urandom_range(1, 100000)));
        end
        test_zero_size(1'b0, 1'b1);
        test_zero_size(1'b1, 1'b0);
        test_zero_size(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        test_timeout($urandom_range(0, 4));
        test_abort_issue(5);
        test_abort_run($urandom_range(0, 4), $urandom_range(1, 40));
        test_overrun($urandom_range(0, 4), $urandom_range(4, 30), 1);
        test_reset_mid($urandom_range(2, 10));
        test_normal($urandom_range(0, 3), $urandom_range(1, 10), 1'b0, 32'd1, 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
